urate_feed: RTL and testbench

Rate-matching input buffer that sits directly upstream of the up-rate stage (`URATE`) and feeds its `in` port. It accepts bursty valid/ready samples from a low-rate producer, stores them in a small FIFO, and presents exactly one sample per `RATE` clocks. It runs a phase counter locked to the up-rate stage's capture counter, so each stored sample is captured exactly once and none is dropped or duplicated.

---
 rtl/urate_feed.sv | 129 ++++++++++++
 tb/tb_urate_feed.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urate_feed.sv
// urate_feed
//
// Rate-matching input buffer for the up-rate stage. Bursty valid/ready
// samples from a low-rate producer are stored in a small FIFO, and exactly
// one sample is presented per RATE clocks. A phase counter runs in lock-step
// with the downstream capture counter because both leave reset on the same
// edge, so each stored sample is captured exactly once.
//
// Ports
//   clk       system clock, shared with the up-rate stage
//   rst       synchronous active-high reset, shared with the up-rate stage
//   in_valid  producer sample valid
//   in_data   producer sample (signed, DWIDTH bits)
//   in_ready  FIFO can accept a sample this cycle
//   out       head-of-FIFO sample, zero when empty (drives up-rate stage `in`)
//   take      high in the cycle the downstream stage captures `out`
//   level     current FIFO occupancy, 0..DEPTH
//   urun      sticky underrun flag, cleared only by rst

module urate_feed #(
    parameter int DWIDTH = 16,
    parameter int F_H    = 60,
    parameter int F_L    = 3,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [DWIDTH-1:0]   in_data,
    output logic                       in_ready,
    output logic signed [DWIDTH-1:0]   out,
    output logic                       take,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       urun
);

    localparam int RATE = F_H / F_L;
    localparam int CW   = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(RATE - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    // A counter narrower than two states or a non-power-of-two FIFO would
    // break the phase lock or the natural pointer wrap.
    if (RATE < 2) begin : g_bad_rate
        $error("urate_feed: F_H/F_L must be at least 2");
    end
    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("urate_feed: DEPTH must be a power of two and at least 2");
    end

    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [AW-1:0]     wptr_q,  wptr_d;
    logic [AW-1:0]     rptr_q,  rptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              urun_q,  urun_d;
    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic takeNow;
    logic isFull;
    logic isEmpty;
    logic pushEn;
    logic popEn;

    // Next-state logic. Full/empty come from the registered level so that
    // in_ready has no combinational dependence on in_valid, and a slot freed
    // by a pop at full only becomes visible on the following cycle.
    always_comb begin
        takeNow = (cnt_q == CNT_LAST);
        isFull  = (level_q == LVL_FULL);
        isEmpty = (level_q == '0);
        pushEn  = in_valid && !isFull;
        popEn   = takeNow && !isEmpty;

        cnt_d   = takeNow ? '0 : cnt_q + CW'(1);
        wptr_d  = pushEn ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = popEn  ? rptr_q + AW'(1) : rptr_q;

        level_d = level_q;
        case ({pushEn, popEn})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A capture with nothing stored means the downstream stage saw a
        // stuffed zero instead of a real sample; remember it until reset.
        urun_d  = urun_q | (takeNow & isEmpty);
    end

    // Control state: counter, pointers, occupancy and the sticky flag all
    // return to zero together so no partial FIFO state survives a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            urun_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            urun_q  <= urun_d;
        end
    end

    // Sample storage needs no reset: stale entries are unreachable once
    // level is zero, because out is forced to zero when empty.
    always_ff @(posedge clk) begin
        if (!rst && pushEn) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    // Outputs are decoded purely from registers, so out never depends on
    // in_data within the same cycle.
    always_comb begin
        in_ready = !isFull;
        take     = takeNow;
        level    = level_q;
        urun     = urun_q;
        out      = isEmpty ? '0 : $signed(mem_q[rptr_q]);
    end

endmodule

// File: tb/tb_urate_feed.sv
// tb_urate_feed
//
// Self-checking bench for urate_feed. A scoreboard queue holds every sample
// the bench expects the FIFO to hold; samples are pushed when the bench
// drives an accepted transfer and popped at each capture cycle, where the
// DUT output is compared with the queue head.

module tb_urate_feed;

    localparam int DWIDTH = 16;
    localparam int F_H    = 60;
    localparam int F_L    = 3;
    localparam int DEPTH  = 8;
    localparam int RATE   = F_H / F_L;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic                     clk      = 1'b0;
    logic                     rst      = 1'b1;
    logic                     in_valid = 1'b0;
    logic signed [DWIDTH-1:0] in_data  = '0;
    logic                     in_ready;
    logic signed [DWIDTH-1:0] out;
    logic                     take;
    logic [LW-1:0]            level;
    logic                     urun;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [DWIDTH-1:0] sb[$];
    int                mcnt  = 0;
    logic              murun = 1'b0;

    logic              obsTake, obsReady, obsUrun;
    logic [DWIDTH-1:0] obsOut;
    logic [LW-1:0]     obsLevel;
    logic              expTake, expReady, expUrun;
    logic [DWIDTH-1:0] expOut;
    logic [LW-1:0]     expLevel;
    int                curCnt;
    logic              accepted;

    urate_feed #(
        .DWIDTH (DWIDTH),
        .F_H    (F_H),
        .F_L    (F_L),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out      (out),
        .take     (take),
        .level    (level),
        .urun     (urun)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: sample DUT and model at the falling edge, drive
    // inputs, then advance the model across the rising edge.
    task automatic step(input logic r, input logic v, input logic [DWIDTH-1:0] d);
        @(negedge clk);
        obsTake  = take;
        obsOut   = out;
        obsLevel = level;
        obsReady = in_ready;
        obsUrun  = urun;
        curCnt   = mcnt;
        expTake  = (mcnt == RATE - 1);
        expOut   = (sb.size() > 0) ? sb[0] : '0;
        expLevel = LW'(sb.size());
        expReady = (sb.size() < DEPTH);
        expUrun  = murun;
        rst      = r;
        in_valid = v;
        in_data  = d;
        accepted = v && expReady && !r;
        @(posedge clk);
        if (r) begin
            sb.delete();
            mcnt  = 0;
            murun = 1'b0;
        end else begin
            if (expTake) begin
                if (sb.size() > 0) void'(sb.pop_front());
                else murun = 1'b1;
            end
            if (accepted) sb.push_back(d);
            mcnt = (mcnt == RATE - 1) ? 0 : mcnt + 1;
        end
    endtask

    task automatic idleUntil(input int target, output logic ok);
        ok = 1'b0;
        for (int g = 0; g < 2 * RATE; g++) begin
            if (mcnt == target) begin
                ok = 1'b1;
                return;
            end
            step(1'b0, 1'b0, '0);
        end
        ok = (mcnt == target);
    endtask

    task automatic test_reset;
        int firstTake;
        firstTake = -1;
        step(1'b1, 1'b1, 16'hAAAA);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 16'h5555);
            testsRun++;
            if ({obsOut, obsLevel, obsReady, obsUrun, obsTake} !== {16'h0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
                testsFailed++;
                $display("[TB] FAIL reset_hold got out/level/ready/urun/take=%h/%0d/%b/%b/%b want 0000/0/1/0/0",
                         obsOut, obsLevel, obsReady, obsUrun, obsTake);
            end
        end
        for (int i = 0; i < RATE; i++) begin
            step(1'b0, 1'b0, '0);
            testsRun++;
            if ({obsTake, obsOut, obsLevel, obsReady, obsUrun} !== {expTake, expOut, expLevel, expReady, expUrun}) begin
                testsFailed++;
                $display("[TB] FAIL reset_state cnt=%0d got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", curCnt,
                         obsTake, obsOut, obsLevel, obsReady, obsUrun, expTake, expOut, expLevel, expReady, expUrun);
            end
            if (obsTake === 1'b1 && firstTake < 0) firstTake = i;
        end
        testsRun++;
        if (firstTake != 19) begin
            testsFailed++;
            $display("[TB] FAIL reset_first_take got cycle %0d want cycle 19", firstTake);
        end
    endtask

    task automatic test_underrun;
        logic delivered;
        delivered = 1'b0;
        for (int i = 0; i < RATE; i++) begin
            step(1'b0, 1'b0, '0);
            testsRun++;
            if ({obsTake, obsOut, obsLevel, obsReady, obsUrun} !== {expTake, expOut, expLevel, expReady, expUrun}) begin
                testsFailed++;
                $display("[TB] FAIL underrun_state cnt=%0d got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", curCnt,
                         obsTake, obsOut, obsLevel, obsReady, obsUrun, expTake, expOut, expLevel, expReady, expUrun);
            end
            testsRun++;
            if ({obsUrun, obsOut} !== {1'b1, 16'h0}) begin
                testsFailed++;
                $display("[TB] FAIL underrun_sticky cnt=%0d got urun/out=%b/%h want 1/0000", curCnt, obsUrun, obsOut);
            end
        end
        step(1'b0, 1'b1, 16'hFFFB);
        for (int g = 0; g < 2 * RATE && !delivered; g++) begin
            step(1'b0, 1'b0, '0);
            testsRun++;
            if ({obsTake, obsOut, obsLevel, obsReady, obsUrun} !== {expTake, expOut, expLevel, expReady, expUrun}) begin
                testsFailed++;
                $display("[TB] FAIL underrun_deliver cnt=%0d got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", curCnt,
                         obsTake, obsOut, obsLevel, obsReady, obsUrun, expTake, expOut, expLevel, expReady, expUrun);
            end
            if (curCnt == RATE - 1 && obsTake === 1'b1 && obsOut === 16'hFFFB) delivered = 1'b1;
        end
        testsRun++;
        if ({delivered, obsUrun} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL underrun_after_push got delivered/urun=%b/%b want 1/1", delivered, obsUrun);
        end
    endtask

    task automatic test_single;
        logic ok;
        idleUntil(5, ok);
        step(1'b0, 1'b1, 16'h1234);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, '0);
            testsRun++;
            if ({obsTake, obsOut, obsLevel, obsReady, obsUrun} !== {expTake, expOut, expLevel, expReady, expUrun}) begin
                testsFailed++;
                $display("[TB] FAIL single_state cnt=%0d got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", curCnt,
                         obsTake, obsOut, obsLevel, obsReady, obsUrun, expTake, expOut, expLevel, expReady, expUrun);
            end
            if (curCnt >= 6 && curCnt <= 19) begin
                testsRun++;
                if (obsOut !== 16'h1234) begin
                    testsFailed++;
                    $display("[TB] FAIL single_hold cnt=%0d got out=%h want 1234", curCnt, obsOut);
                end
            end
        end
        testsRun++;
        if ({ok, curCnt[7:0], obsLevel, obsOut} !== {1'b1, 8'd0, 4'd0, 16'h0}) begin
            testsFailed++;
            $display("[TB] FAIL single_popped got ok/cnt/level/out=%b/%0d/%0d/%h want 1/0/0/0000",
                     ok, curCnt, obsLevel, obsOut);
        end
    endtask

    task automatic test_burst;
        logic ok;
        logic sawFull;
        logic [DWIDTH-1:0] capQ[$];
        int k;
        int g;
        sawFull = 1'b0;
        k = 1;
        idleUntil(0, ok);
        for (g = 0; g < 20 * RATE; g++) begin
            if (k > 10 && sb.size() == 0) break;
            step(1'b0, k <= 10, DWIDTH'(k));
            testsRun++;
            if ({obsTake, obsOut, obsLevel, obsReady, obsUrun} !== {expTake, expOut, expLevel, expReady, expUrun}) begin
                testsFailed++;
                $display("[TB] FAIL burst_state cnt=%0d got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", curCnt,
                         obsTake, obsOut, obsLevel, obsReady, obsUrun, expTake, expOut, expLevel, expReady, expUrun);
            end
            if (curCnt == RATE - 1 && obsTake === 1'b1) capQ.push_back(obsOut);
            if (obsLevel === LW'(DEPTH)) begin
                sawFull = 1'b1;
                testsRun++;
                if (obsReady !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL burst_full_ready cnt=%0d got in_ready=%b want 0", curCnt, obsReady);
                end
            end
            if (accepted) k++;
        end
        testsRun++;
        if ({ok, sawFull, g < 20 * RATE} !== 3'b111) begin
            testsFailed++;
            $display("[TB] FAIL burst_progress got align/full/done=%b/%b/%b want 1/1/1", ok, sawFull, g < 20 * RATE);
        end
        testsRun++;
        if (capQ.size() != 10) begin
            testsFailed++;
            $display("[TB] FAIL burst_count got %0d captures want 10", capQ.size());
        end
        for (int i = 0; i < capQ.size() && i < 10; i++) begin
            testsRun++;
            if (capQ[i] !== DWIDTH'(i + 1)) begin
                testsFailed++;
                $display("[TB] FAIL burst_order idx=%0d got %h want %h", i, capQ[i], DWIDTH'(i + 1));
            end
        end
    endtask

    task automatic test_simul;
        logic ok;
        logic allOk;
        allOk = 1'b1;
        idleUntil(0, ok);
        allOk &= ok;
        for (int j = 0; j < 3; j++) step(1'b0, 1'b1, DWIDTH'(16'h0A00 + j));
        for (int j = 0; j < 9; j++) begin
            idleUntil(RATE - 1, ok);
            allOk &= ok;
            step(1'b0, 1'b1, (j == 0) ? 16'h7FFF : DWIDTH'(16'h0100 + j));
            testsRun++;
            if ({obsTake, obsLevel} !== {1'b1, 4'd3}) begin
                testsFailed++;
                $display("[TB] FAIL simul_take_cycle pass=%0d got take/level=%b/%0d want 1/3", j, obsTake, obsLevel);
            end
            step(1'b0, 1'b0, '0);
            testsRun++;
            if ({obsLevel, obsOut} !== {4'd3, expOut}) begin
                testsFailed++;
                $display("[TB] FAIL simul_level pass=%0d got level/out=%0d/%h want 3/%h", j, obsLevel, obsOut, expOut);
            end
        end
        for (int g = 0; g < 10 * RATE && sb.size() > 0; g++) begin
            step(1'b0, 1'b0, '0);
            testsRun++;
            if ({obsTake, obsOut, obsLevel, obsReady, obsUrun} !== {expTake, expOut, expLevel, expReady, expUrun}) begin
                testsFailed++;
                $display("[TB] FAIL simul_drain cnt=%0d got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", curCnt,
                         obsTake, obsOut, obsLevel, obsReady, obsUrun, expTake, expOut, expLevel, expReady, expUrun);
            end
        end
        testsRun++;
        if ({allOk, sb.size() == 0} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL simul_progress got align/drained=%b/%b want 1/1", allOk, sb.size() == 0);
        end
    endtask

    task automatic test_reset_mid;
        logic ok;
        int firstTake;
        firstTake = -1;
        idleUntil(0, ok);
        for (int j = 0; j < 5; j++) step(1'b0, 1'b1, DWIDTH'(16'h0B00 + j));
        idleUntil(12, ok);
        step(1'b1, 1'b1, 16'hDEAD);
        testsRun++;
        if ({ok, obsLevel, obsUrun} !== {1'b1, 4'd5, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL midrst_before got ok/level/urun=%b/%0d/%b want 1/5/1", ok, obsLevel, obsUrun);
        end
        for (int i = 0; i < RATE + 5; i++) begin
            step(1'b0, 1'b0, '0);
            testsRun++;
            if ({obsTake, obsOut, obsLevel, obsReady, obsUrun} !== {expTake, expOut, expLevel, expReady, expUrun}) begin
                testsFailed++;
                $display("[TB] FAIL midrst_state cnt=%0d got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", curCnt,
                         obsTake, obsOut, obsLevel, obsReady, obsUrun, expTake, expOut, expLevel, expReady, expUrun);
            end
            if (i == 0) begin
                testsRun++;
                if ({obsLevel, obsOut, obsUrun, obsTake} !== {4'd0, 16'h0, 1'b0, 1'b0}) begin
                    testsFailed++;
                    $display("[TB] FAIL midrst_cleared got level/out/urun/take=%0d/%h/%b/%b want 0/0000/0/0",
                             obsLevel, obsOut, obsUrun, obsTake);
                end
            end
            if (obsTake === 1'b1 && firstTake < 0) firstTake = i;
        end
        testsRun++;
        if (firstTake != 19) begin
            testsFailed++;
            $display("[TB] FAIL midrst_realign got first take at cycle %0d want cycle 19", firstTake);
        end
    endtask

    initial begin
        test_reset();
        test_underrun();
        test_single();
        test_burst();
        test_simul();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
